// File: rtl/window_shift_scheduler_pkg.sv
// Shared definitions for the window shift scheduler.
//   state_t        : controller states (IDLE, SHIFT, EVAL)
//   *_DEFAULT      : default event width and window depth
//   fill_width()   : bits needed to hold a fill level of 0..depth
package window_shift_scheduler_pkg;

    localparam int DATA_W_DEFAULT = 64;
    localparam int DEPTH_DEFAULT  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EVAL  = 2'd2
    } state_t;

    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/window_shift_scheduler_period_ticker.sv
// Free-running period counter for the window shift scheduler.
// Counts 0..PERIOD-1 on every enabled cycle and flags the wrap.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-low
//   en   : count enable; 0 freezes the counter
//   tick : high during the enabled cycle whose edge wraps the counter
module period_ticker
    import window_shift_scheduler_pkg::*;
#(
    parameter int PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;

    // Combinational so the scheduler sees the tick in the same cycle the
    // counter wraps; it is inherently one cycle wide.
    assign tick = en && (count == LAST);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/window_shift_scheduler.sv
// Controller for the sliding-window shift datapath of the RTLola monitor.
// Accepts events over valid/ready, issues one-cycle shift enables with the
// registered event value, tracks window fill and raises periodic evaluation
// requests, counting ticks that could not be raised.
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-low reset
//   en            : global enable; 0 freezes all state
//   in_valid/in_data/in_ready : input event handshake
//   shift_en/shift_data       : one-cycle shift strobe and its data
//   fill_count/window_full    : number of valid window slots, full flag
//   eval_valid/eval_partial/eval_ready : evaluation request handshake
//   missed_ticks  : saturating count of dropped period ticks
module window_shift_scheduler
    import window_shift_scheduler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int PERIOD = 8,
    parameter int MISS_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           in_valid,
    input  logic signed [DATA_W-1:0]       in_data,
    output logic                           in_ready,
    output logic                           shift_en,
    output logic signed [DATA_W-1:0]       shift_data,
    output logic [fill_width(DEPTH)-1:0]   fill_count,
    output logic                           window_full,
    output logic                           eval_valid,
    output logic                           eval_partial,
    input  logic                           eval_ready,
    output logic [MISS_W-1:0]              missed_ticks
);

    localparam int               FILL_W = fill_width(DEPTH);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(DEPTH);

    state_t state;
    state_t state_next;
    logic   pending_eval;
    logic   tick;
    logic   raise_eval;
    logic   accept;
    logic   busy;

    period_ticker #(
        .PERIOD (PERIOD)
    ) u_ticker (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // State register: holds while en=0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    // Next-state logic. A pending evaluation wins over a waiting event.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (pending_eval) begin
                    state_next = EVAL;
                end else if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT:   state_next = IDLE;
            EVAL: begin
                if (eval_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic. eval_valid comes straight from the state register, so it
    // holds through en=0 and drops on the reset edge.
    always_comb begin
        in_ready    = en && (state == IDLE) && !pending_eval;
        shift_en    = en && (state == SHIFT);
        eval_valid  = (state == EVAL);
        window_full = (fill_count == FULL);
    end

    // tick, in_ready and shift_en already carry en, so the terms below only
    // fire on enabled cycles.
    assign raise_eval = en && (state == IDLE) && pending_eval;
    assign accept     = in_valid && in_ready;
    // A tick cannot be queued while one is pending or being served.
    assign busy       = pending_eval || (state == EVAL);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_eval <= 1'b0;
            missed_ticks <= '0;
            eval_partial <= 1'b0;
            shift_data   <= '0;
            fill_count   <= '0;
        end else begin
            // Clearing wins: a tick landing on the IDLE->EVAL cycle is
            // counted as missed below rather than re-queued.
            if (raise_eval) begin
                pending_eval <= 1'b0;
            end else if (tick && !busy) begin
                pending_eval <= 1'b1;
            end

            if (tick && busy && (missed_ticks != '1)) begin
                missed_ticks <= missed_ticks + MISS_W'(1);
            end

            // Latched when the request is raised and held until the next one.
            if (raise_eval) begin
                eval_partial <= !window_full;
            end

            if (accept) begin
                shift_data <= in_data;
            end

            // The window only fills; reset is the only way to empty it.
            if (shift_en && (fill_count != FULL)) begin
                fill_count <= fill_count + FILL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_window_shift_scheduler.sv
module tb_window_shift_scheduler;

    localparam int DATA_W   = 64;
    localparam int DEPTH    = 6;
    localparam int PERIOD   = 8;
    localparam int MISS_W   = 8;
    localparam int FILL_W   = $clog2(DEPTH + 1);
    localparam int MISS_MAX = (1 << MISS_W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_SHIFT = 1;
    localparam int M_EVAL  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     shift_en;
    logic signed [DATA_W-1:0] shift_data;
    logic [FILL_W-1:0]        fill_count;
    logic                     window_full;
    logic                     eval_valid;
    logic                     eval_partial;
    logic                     eval_ready;
    logic [MISS_W-1:0]        missed_ticks;

    always #5 clk = ~clk;

    window_shift_scheduler #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PERIOD (PERIOD),
        .MISS_W (MISS_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .shift_en     (shift_en),
        .shift_data   (shift_data),
        .fill_count   (fill_count),
        .window_full  (window_full),
        .eval_valid   (eval_valid),
        .eval_partial (eval_partial),
        .eval_ready   (eval_ready),
        .missed_ticks (missed_ticks)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int c        = 0;
    bit compare_on = 1'b0;
    bit directed   = 1'b1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, c, actual, expected);
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode;
    int          m_phase;      // enabled cycles since reset, modulo PERIOD
    bit          m_pend;
    bit          m_partial;
    int          m_fill;
    int          m_missed;
    logic [63:0] m_last;
    logic [63:0] m_q[$];       // accepted events not yet shifted

    task automatic compare();
        bit exp_ready;
        bit exp_shift;
        exp_ready = en && (m_mode == M_IDLE) && !m_pend;
        exp_shift = en && (m_mode == M_SHIFT);
        check("in_ready", in_ready, exp_ready);
        check("shift_en", shift_en, exp_shift);
        check("shift_data", shift_data, m_last);
        if (exp_shift && m_q.size() > 0) check("shift_order", shift_data, m_q[0]);
        check("fill_count", fill_count, m_fill);
        check("window_full", window_full, m_fill == DEPTH);
        check("eval_valid", eval_valid, m_mode == M_EVAL);
        check("eval_partial", eval_partial, m_partial);
        check("missed_ticks", missed_ticks, m_missed);
    endtask

    task automatic model_update();
        bit tick;
        bit busy;
        bit old_pend;
        if (!rst) begin
            m_mode = M_IDLE; m_phase = 0; m_pend = 0; m_partial = 0;
            m_fill = 0; m_missed = 0; m_last = '0; m_q.delete();
            return;
        end
        if (!en) return;
        tick     = (m_phase == PERIOD - 1);
        busy     = m_pend || (m_mode == M_EVAL);
        old_pend = m_pend;
        m_phase  = (m_phase + 1) % PERIOD;
        if (tick) begin
            if (busy) m_missed = (m_missed < MISS_MAX) ? m_missed + 1 : MISS_MAX;
            else      m_pend = 1;
        end
        case (m_mode)
            M_IDLE: begin
                if (old_pend) begin
                    m_mode    = M_EVAL;
                    m_partial = (m_fill != DEPTH);
                    m_pend    = 0;
                end else if (in_valid) begin
                    m_last = in_data;
                    m_q.push_back(in_data);
                    m_mode = M_SHIFT;
                end
            end
            M_SHIFT: begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                if (m_fill < DEPTH) m_fill++;
                m_mode = M_IDLE;
            end
            default: begin
                if (eval_ready) m_mode = M_IDLE;
            end
        endcase
    endtask

    // Hand-computed expectations for the directed sequence.
    task automatic directed_checks();
        if (!directed) return;
        case (c)
            0:  check("lit_c0_in_ready", in_ready, 1);
            1:  begin check("lit_c1_shift_en", shift_en, 1); check("lit_c1_data", shift_data, 1); end
            3:  check("lit_c3_data", shift_data, 2);
            5:  check("lit_c5_data", shift_data, 3);
            8:  begin check("lit_c8_tick_preempts", in_ready, 0); check("lit_c8_fill", fill_count, 4); end
            9:  begin check("lit_c9_eval_valid", eval_valid, 1); check("lit_c9_partial", eval_partial, 1);
                      check("lit_c9_in_ready", in_ready, 0); end
            14: begin check("lit_c14_fill", fill_count, 6); check("lit_c14_full", window_full, 1); end
            15: begin check("lit_c15_shift_en", shift_en, 1); check("lit_c15_data", shift_data, 7); end
            16: check("lit_c16_fill_sat", fill_count, 6);
            17: check("lit_c17_partial", eval_partial, 0);
            36: begin check("lit_c36_eval_held", eval_valid, 1); check("lit_c36_missed", missed_ticks, 2); end
            38: begin check("lit_c38_in_ready", in_ready, 1); check("lit_c38_eval_done", eval_valid, 0); end
            39: check("lit_c39_data", shift_data, 8);
            41, 43, 45: begin check("lit_en0_eval_valid", eval_valid, 1); check("lit_en0_in_ready", in_ready, 0); end
            47: check("lit_c47_eval_done", eval_valid, 0);
            48: check("lit_c48_frozen_period", in_ready, 1);
            53: begin check("lit_c53_tick", in_ready, 0); check("lit_c53_missed", missed_ticks, 2); end
            56: check("lit_c56_shift_en", shift_en, 1);
            57: begin check("lit_rst_shift_en", shift_en, 0); check("lit_rst_fill", fill_count, 0);
                      check("lit_rst_missed", missed_ticks, 0); check("lit_rst_eval", eval_valid, 0);
                      check("lit_rst_data", shift_data, 0); end
            2120: check("lit_missed_saturated", missed_ticks, MISS_MAX);
            default: ;
        endcase
    endtask

    // ---------------- cycle helpers ----------------
    task automatic drive(input bit r, input bit e, input bit v, input logic [63:0] d, input bit rdy);
        rst = r; en = e; in_valid = v; in_data = d; eval_ready = rdy;
    endtask

    task automatic step_begin();
        @(negedge clk);
        if (compare_on) compare();
        directed_checks();
    endtask

    task automatic step_end();
        @(posedge clk);
        model_update();
        #1;
        c++;
    endtask

    int ev;

    initial begin
        drive(0, 1, 0, '0, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            model_update();
            #1;
        end
        compare_on = 1'b1;
        c  = 0;
        ev = 1;

        // Directed sequence, one stimulus row per cycle.
        while (c <= 2121) begin
            bit hs;
            if      (c < 17)   drive(1, 1, 1, ev, 1);
            else if (c < 37)   drive(1, 1, 1, ev, 0);
            else if (c < 41)   drive(1, 1, 1, ev, 1);
            else if (c < 46)   drive(1, 0, 0, ev, 1);
            else if (c < 55)   drive(1, 1, 0, ev, 1);
            else if (c == 55)  drive(1, 1, 1, ev, 1);
            else if (c == 56)  drive(0, 1, 0, ev, 1);
            else if (c < 2121) drive(1, 1, 0, ev, (c == 57)); // stall eval to saturate missed
            else               drive(1, 1, 0, ev, 1);
            step_begin();
            hs = in_valid && in_ready;
            step_end();
            if (hs) ev++;
        end

        // Randomised traffic against the model.
        directed = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 9) != 0),
                  $urandom_range(0, 1),
                  {$urandom, $urandom},
                  ($urandom_range(0, 9) < 6));
            step_begin();
            step_end();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
